elevator_car_drive: RTL and testbench
=====================================

// Module: elevator_car_drive
// PURPOSE
//  Car-motion stage directly downstream of sequential_elevator. Consumes its elevator_direction and
//  door_open outputs, times inter-floor travel, tracks car position, and returns a one-cycle
//  elevator_arrived pulse to the controller. Floor one-hot output can drive the floor LEDs.
//  Replaces the hand-driven elevator_arrived stimulus with a closed-loop model.
// PARAMETERS
//  NUM_FLOORS     3  floors served, index 0..NUM_FLOORS-1 (>=2)
//  TRAVEL_CYCLES  8  clk cycles to move one floor (>=2)
//  DWELL_CYCLES   4  min IDLE cycles after an arrival before the next departure (>=1)
// PORTS
//  clk                 in   1                    system clock, rising edge
//  rst                 in   1                    synchronous, active-high reset
//  elevator_direction  in   2                    00 stop, 01 up, 10 down, 11 illegal (= stop)
//  door_open           in   1                    door interlock; 1 inhibits departure
//  elevator_arrived    out  1                    registered 1-cycle pulse on reaching next floor
//  car_floor           out  $clog2(NUM_FLOORS)   current floor index
//  car_floor_onehot    out  NUM_FLOORS           bit car_floor set
//  moving              out  1                    1 while in TRAVEL
//  fault               out  1                    sticky fault flag (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered. Reset values: car_floor=0, car_floor_onehot=1, elevator_arrived=0,
//    moving=0, fault=0, state=IDLE, travel_cnt=0, dwell_cnt=0 (departure allowed immediately).
//  - Reset takes priority over all activity, including mid-travel: next cycle = reset values.
//  - FSM states: IDLE, TRAVEL, ARRIVE, FAULT.
//  - IDLE: moving=0. dwell_cnt decrements to 0. Departure when dwell_cnt==0 && !door_open &&
//    (dir==01 && car_floor<NUM_FLOORS-1 || dir==10 && car_floor>0): latch dir, travel_cnt=0,
//    go to TRAVEL. Up at top, down at bottom, 00, 11: stay IDLE (no position change).
//  - TRAVEL: moving=1; travel_cnt increments each cycle. When travel_cnt==TRAVEL_CYCLES-1:
//    car_floor +/-1 per latched dir, onehot updated on the same edge, go to ARRIVE.
//    Car never stops between floors: input dir changes / door_open mid-travel are ignored.
//  - Latency: departure edge k -> moving high for TRAVEL_CYCLES cycles -> elevator_arrived high
//    in the cycle after edge k+TRAVEL_CYCLES, together with the new car_floor.
//  - ARRIVE: elevator_arrived=1 for exactly one cycle; dwell_cnt=DWELL_CYCLES; go to IDLE.
//    A held direction command departs again exactly DWELL_CYCLES cycles after re-entering IDLE.
//  - Counter widths: travel_cnt $clog2(TRAVEL_CYCLES), dwell_cnt $clog2(DWELL_CYCLES+1); no wrap.
//  - FAULT: reachable only with macro; moving=0, no arrival, car_floor frozen until rst.
// CONFIGURATION
//  ELEVATOR_CAR_DRIVE_FAULT_EN defined: fault=1 and state=FAULT on the next edge when (a) IDLE with
//    dir==01 at top floor or dir==10 at floor 0, (b) TRAVEL with dir equal to the opposite of
//    latched dir, or (c) TRAVEL with door_open=1. In-flight travel aborts; no arrival pulse.
//  Not defined: fault tied 0, FAULT state not built; those conditions ignored as above.
// TESTING
//  1 rst=1 two cycles -> car_floor=0, onehot=3'b001, arrived=0, moving=0, fault=0.
//  2 dir=01 held from floor 0 -> moving=1 for 8 cycles, arrived 1 cycle, car_floor=1/onehot=010;
//    departs again 4 cycles later, arrives at floor 2 (onehot=100).
//  3 At floor 2, dir=01 held 20 cycles -> no movement, moving=0; fault=0 (macro off) / 1 (on).
//  4 Floor 1, door_open=1, dir=10 -> no departure; door_open=0 -> departs next edge,
//    arrived 8 cycles later, car_floor=0.
//  5 Floor 0 -> up, switch dir to 10 at travel cycle 3 -> macro off: arrives floor 1 on schedule;
//    macro on: fault=1, moving=0, no arrived pulse, car_floor stays 0.
//  6 rst asserted at travel cycle 5 -> next cycle car_floor=0, moving=0, no arrived pulse.

Source files
------------

// File: rtl/elevator_car_drive.sv
// Car-motion stage for sequential_elevator: times floor-to-floor travel, tracks position, pulses elevator_arrived.
// Optional sticky fault detection is enabled by defining ELEVATOR_CAR_DRIVE_FAULT_EN.
module elevator_car_drive #(
   parameter int NUM_FLOORS    = 3,
   parameter int TRAVEL_CYCLES = 8,
   parameter int DWELL_CYCLES  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    elevator_direction,
   input  logic                          door_open,
   output logic                          elevator_arrived,
   output logic [$clog2(NUM_FLOORS)-1:0] car_floor,
   output logic [NUM_FLOORS-1:0]         car_floor_onehot,
   output logic                          moving,
   output logic                          fault
);

`ifdef ELEVATOR_CAR_DRIVE_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   localparam int FLOOR_W  = $clog2(NUM_FLOORS);
   localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES);
   localparam int DWELL_W  = $clog2(DWELL_CYCLES + 1);

   localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
   localparam logic [DWELL_W-1:0]  DWELL_LOAD  = DWELL_W'(DWELL_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRAVEL,
      ST_ARRIVE,
      ST_FAULT
   } state_t;

   state_t              state;
   logic [TRAVEL_W-1:0] travel_cnt;
   logic [DWELL_W-1:0]  dwell_cnt;
   logic                going_up;

   logic req_up;
   logic req_down;
   logic at_top;
   logic at_bottom;
   logic can_depart;
   logic idle_fault;
   logic travel_fault;

   // Direction code 2'b11 decodes to neither request, so it behaves as stop.
   assign req_up     = (elevator_direction == 2'b01);
   assign req_down   = (elevator_direction == 2'b10);
   assign at_top     = (car_floor == TOP_FLOOR);
   assign at_bottom  = (car_floor == '0);
   assign can_depart = (dwell_cnt == '0) && !door_open &&
                       ((req_up && !at_top) || (req_down && !at_bottom));

   assign idle_fault   = FAULT_EN && ((req_up && at_top) || (req_down && at_bottom));
   assign travel_fault = FAULT_EN && (door_open || (going_up ? req_down : req_up));

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values,
   // and the synchronous reset branch comes first so it overrides any in-flight travel.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         travel_cnt       <= '0;
         dwell_cnt        <= '0;
         going_up         <= 1'b0;
         car_floor        <= '0;
         car_floor_onehot <= NUM_FLOORS'(1);
         elevator_arrived <= 1'b0;
         moving           <= 1'b0;
         fault            <= 1'b0;
      end else begin
         // NOTE: the arrival pulse defaults low every cycle; only the TRAVEL exit raises it.
         elevator_arrived <= 1'b0;
         case (state)
            ST_IDLE: begin
               moving <= 1'b0;
               if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
               if (idle_fault) begin
                  fault <= 1'b1;
                  state <= ST_FAULT;
               end else if (can_depart) begin
                  going_up   <= req_up;
                  travel_cnt <= '0;
                  moving     <= 1'b1;
                  state      <= ST_TRAVEL;
               end
            end

            ST_TRAVEL: begin
               if (travel_fault) begin
                  fault      <= 1'b1;
                  moving     <= 1'b0;
                  travel_cnt <= '0;
                  state      <= ST_FAULT;
               end else if (travel_cnt == TRAVEL_LAST) begin
                  travel_cnt       <= '0;
                  moving           <= 1'b0;
                  elevator_arrived <= 1'b1;
                  dwell_cnt        <= DWELL_LOAD;
                  if (going_up) begin
                     car_floor        <= car_floor + FLOOR_W'(1);
                     car_floor_onehot <= car_floor_onehot << 1;
                  end else begin
                     car_floor        <= car_floor - FLOOR_W'(1);
                     car_floor_onehot <= car_floor_onehot >> 1;
                  end
                  state <= ST_ARRIVE;
               end else begin
                  moving     <= 1'b1;
                  travel_cnt <= travel_cnt + 1'b1;
               end
            end

            // The dwell count runs from the arrival cycle, so a held command leaves
            // exactly DWELL_CYCLES cycles after the return to IDLE.
            ST_ARRIVE: begin
               moving    <= 1'b0;
               dwell_cnt <= dwell_cnt - 1'b1;
               state     <= ST_IDLE;
            end

            ST_FAULT: begin
               moving <= 1'b0;
               fault  <= 1'b1;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_car_drive.sv
// Directed bench for elevator_car_drive with default parameters (3 floors, 8 travel, 4 dwell).
// Expectations adapt when ELEVATOR_CAR_DRIVE_FAULT_EN is defined.
module tb_elevator_car_drive;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] elevator_direction = 2'b00;
   logic       door_open = 1'b0;
   logic       elevator_arrived;
   logic [1:0] car_floor;
   logic [2:0] car_floor_onehot;
   logic       moving;
   logic       fault;

   int vectors     = 0;
   int miscompares = 0;

`ifdef ELEVATOR_CAR_DRIVE_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   elevator_car_drive #(
      .NUM_FLOORS   (3),
      .TRAVEL_CYCLES(8),
      .DWELL_CYCLES (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .elevator_direction(elevator_direction),
      .door_open         (door_open),
      .elevator_arrived  (elevator_arrived),
      .car_floor         (car_floor),
      .car_floor_onehot  (car_floor_onehot),
      .moving            (moving),
      .fault             (fault)
   );

   always #5 clk = ~clk;

   // Observed status word: {moving, arrived, floor[1:0], onehot[2:0], fault}.
   function automatic logic [7:0] status();
      return {moving, elevator_arrived, car_floor, car_floor_onehot, fault};
   endfunction

   function automatic logic [7:0] expv(input logic mv, input logic arr, input logic [1:0] fl,
                                       input logic flt);
      logic [2:0] oh;
      oh = 3'b001 << fl;
      return {mv, arr, fl, oh, flt};
   endfunction

   // Advance n rising edges, returning on the following falling edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      elevator_direction = 2'b00;
      door_open = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] exp;
      rst = 1'b1;
      elevator_direction = 2'b01;
      tick(2);
      exp = expv(1'b0, 1'b0, 2'd0, 1'b0);
      vectors++;
      if (status() !== exp) begin
         miscompares++;
         $display("FAIL reset_hold: got %b expected %b", status(), exp);
      end
      elevator_direction = 2'b00;
      rst = 1'b0;
      tick(1);
      vectors++;
      if (status() !== exp) begin
         miscompares++;
         $display("FAIL reset_release: got %b expected %b", status(), exp);
      end
   endtask

   task automatic test_up_sequence();
      logic [7:0] exp;
      elevator_direction = 2'b01;
      for (int trip = 0; trip < 2; trip++) begin
         for (int i = 0; i < 8; i++) begin
            tick(1);
            exp = expv(1'b1, 1'b0, 2'(trip), 1'b0);
            vectors++;
            if (status() !== exp) begin
               miscompares++;
               $display("FAIL up_travel trip %0d cyc %0d: got %b expected %b", trip, i, status(), exp);
            end
         end
         tick(1);
         exp = expv(1'b0, 1'b1, 2'(trip + 1), 1'b0);
         vectors++;
         if (status() !== exp) begin
            miscompares++;
            $display("FAIL up_arrive trip %0d: got %b expected %b", trip, status(), exp);
         end
         if (trip == 0) begin
            for (int i = 0; i < 4; i++) begin
               tick(1);
               exp = expv(1'b0, 1'b0, 2'd1, 1'b0);
               vectors++;
               if (status() !== exp) begin
                  miscompares++;
                  $display("FAIL up_dwell cyc %0d: got %b expected %b", i, status(), exp);
               end
            end
         end
      end
   endtask

   task automatic test_top_hold();
      logic [7:0] exp;
      elevator_direction = 2'b01;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         exp = expv(1'b0, 1'b0, 2'd2, FAULT_EN && (i >= 1));
         vectors++;
         if (status() !== exp) begin
            miscompares++;
            $display("FAIL top_hold cyc %0d: got %b expected %b", i, status(), exp);
         end
      end
      elevator_direction = 2'b00;
   endtask

   task automatic test_door_interlock();
      logic [7:0] exp;
      do_reset();
      elevator_direction = 2'b01;
      tick(1);
      elevator_direction = 2'b00;
      tick(8);
      exp = expv(1'b0, 1'b1, 2'd1, 1'b0);
      vectors++;
      if (status() !== exp) begin
         miscompares++;
         $display("FAIL door_setup_arrive: got %b expected %b", status(), exp);
      end
      door_open = 1'b1;
      elevator_direction = 2'b10;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         exp = expv(1'b0, 1'b0, 2'd1, 1'b0);
         vectors++;
         if (status() !== exp) begin
            miscompares++;
            $display("FAIL door_hold cyc %0d: got %b expected %b", i, status(), exp);
         end
      end
      door_open = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         exp = expv(1'b1, 1'b0, 2'd1, 1'b0);
         vectors++;
         if (status() !== exp) begin
            miscompares++;
            $display("FAIL door_depart cyc %0d: got %b expected %b", i, status(), exp);
         end
      end
      tick(1);
      exp = expv(1'b0, 1'b1, 2'd0, 1'b0);
      vectors++;
      if (status() !== exp) begin
         miscompares++;
         $display("FAIL door_arrive_down: got %b expected %b", status(), exp);
      end
      elevator_direction = 2'b00;
   endtask

   task automatic test_dir_change();
      logic [7:0] exp;
      tick(6);
      elevator_direction = 2'b01;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         exp = expv(1'b1, 1'b0, 2'd0, 1'b0);
         vectors++;
         if (status() !== exp) begin
            miscompares++;
            $display("FAIL dirchg_pre cyc %0d: got %b expected %b", i, status(), exp);
         end
      end
      elevator_direction = 2'b10;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         exp = expv(!FAULT_EN, 1'b0, 2'd0, FAULT_EN);
         vectors++;
         if (status() !== exp) begin
            miscompares++;
            $display("FAIL dirchg_post cyc %0d: got %b expected %b", i, status(), exp);
         end
      end
      tick(1);
      exp = expv(1'b0, !FAULT_EN, FAULT_EN ? 2'd0 : 2'd1, FAULT_EN);
      vectors++;
      if (status() !== exp) begin
         miscompares++;
         $display("FAIL dirchg_arrive: got %b expected %b", status(), exp);
      end
      elevator_direction = 2'b00;
   endtask

   task automatic test_illegal_dir();
      logic [7:0] exp;
      do_reset();
      elevator_direction = 2'b11;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         exp = expv(1'b0, 1'b0, 2'd0, 1'b0);
         vectors++;
         if (status() !== exp) begin
            miscompares++;
            $display("FAIL illegal_dir cyc %0d: got %b expected %b", i, status(), exp);
         end
      end
      elevator_direction = 2'b00;
   endtask

   task automatic test_reset_mid_travel();
      logic [7:0] exp;
      do_reset();
      elevator_direction = 2'b01;
      tick(1);
      elevator_direction = 2'b00;
      tick(8);
      tick(6);
      elevator_direction = 2'b01;
      tick(6);
      exp = expv(1'b1, 1'b0, 2'd1, 1'b0);
      vectors++;
      if (status() !== exp) begin
         miscompares++;
         $display("FAIL midrst_travel: got %b expected %b", status(), exp);
      end
      rst = 1'b1;
      elevator_direction = 2'b00;
      tick(1);
      exp = expv(1'b0, 1'b0, 2'd0, 1'b0);
      vectors++;
      if (status() !== exp) begin
         miscompares++;
         $display("FAIL midrst_reset: got %b expected %b", status(), exp);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         vectors++;
         if (status() !== exp) begin
            miscompares++;
            $display("FAIL midrst_after cyc %0d: got %b expected %b", i, status(), exp);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_up_sequence();
      test_top_hold();
      test_door_interlock();
      test_dir_change();
      test_illegal_dir();
      test_reset_mid_travel();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
